// File: rtl/ext_mem_port_ctrl.sv
// External memory port controller: boot stream sequencer plus load/store arbiter.
// Build option: define ROUND_ROBIN_ARB_EN for round-robin RUN arbitration (default: fixed store priority).
package ext_mem_port_ctrl_pkg;
  localparam int unsigned WIDTH_DATA   = 32;
  localparam int unsigned WIDTH_EXADDR = 16;

  typedef struct packed {
    logic                  v;
    logic                  a;
    logic                  r;
    logic                  c;
    logic [WIDTH_DATA-1:0] d;
  } FTk_t;

  typedef struct packed {
    logic n;
  } BTk_t;
endpackage

module ext_mem_port_ctrl
  import ext_mem_port_ctrl_pkg::*;
#(
  parameter int unsigned BOOT_PAD  = 3,
  parameter int unsigned BOOT_LEN  = 5,
  parameter int unsigned BOOT_BASE = 0,
  parameter int unsigned WIDTH_CNT = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    I_Boot,
  input  logic                    I_Ld_Req,
  input  logic [WIDTH_EXADDR-1:0] I_Ld_Addr,
  output FTk_t                    O_Ld_FTk,
  input  BTk_t                    I_Ld_BTk,
  input  logic                    I_St_Req,
  input  logic [WIDTH_EXADDR-1:0] I_St_Addr,
  input  FTk_t                    I_St_FTk,
  output BTk_t                    O_St_BTk,
  output logic                    O_Mem_En,
  output logic                    O_Mem_We,
  output logic [WIDTH_EXADDR-1:0] O_Mem_Addr,
  output logic [WIDTH_DATA-1:0]   O_Mem_WData,
  input  logic [WIDTH_DATA-1:0]   I_Mem_RData,
  output logic                    O_Boot_Done
);

  localparam logic [WIDTH_CNT-1:0] PAD_LAST = WIDTH_CNT'(BOOT_PAD - 1);
  localparam logic [WIDTH_CNT-1:0] LEN_END  = WIDTH_CNT'(BOOT_LEN);

  typedef enum logic [1:0] {S_IDLE, S_PAD, S_DATA, S_RUN} state_t;

  state_t                 state_q, state_d;
  logic [WIDTH_CNT-1:0]   cnt_q, cnt_d, cnt_inc;
  logic                   tok_v_q, tok_v_d;
  logic                   tok_a_q, tok_a_d;
  logic                   fresh_q, fresh_d;
  logic [WIDTH_DATA-1:0]  d_hold_q, d_hold_d;
  logic                   done_q, done_d;
  logic                   mem_en, mem_we, st_n;
  logic [WIDTH_EXADDR-1:0] mem_addr;
  logic [WIDTH_DATA-1:0]  mem_wdata, ld_d;
  logic                   ld_stall, ld_req, st_req, ld_gnt, st_gnt;
`ifdef ROUND_ROBIN_ARB_EN
  logic                   st_last_q, st_last_d;
`endif

  logic unused_st_tk;
  assign unused_st_tk = ^{I_St_FTk.a, I_St_FTk.r, I_St_FTk.c};

  function automatic logic [WIDTH_EXADDR-1:0] boot_addr(input logic [WIDTH_CNT-1:0] idx);
    return WIDTH_EXADDR'(BOOT_BASE) + WIDTH_EXADDR'(idx);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tok_v_q  <= 1'b0;
      tok_a_q  <= 1'b0;
      fresh_q  <= 1'b0;
      d_hold_q <= '0;
      done_q   <= 1'b0;
`ifdef ROUND_ROBIN_ARB_EN
      st_last_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tok_v_q  <= tok_v_d;
      tok_a_q  <= tok_a_d;
      fresh_q  <= fresh_d;
      d_hold_q <= d_hold_d;
      done_q   <= done_d;
`ifdef ROUND_ROBIN_ARB_EN
      st_last_q <= st_last_d;
`endif
    end
  end

  // Next state, token register updates and memory port drive
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cnt_inc   = cnt_q + 1'b1;
    tok_v_d   = tok_v_q;
    tok_a_d   = tok_a_q;
    fresh_d   = 1'b0;
    d_hold_d  = fresh_q ? I_Mem_RData : d_hold_q;
    done_d    = done_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    st_n      = 1'b1;
    ld_stall  = tok_v_q & I_Ld_BTk.n;
    ld_req    = I_Ld_Req & ~ld_stall;
    st_req    = I_St_Req & I_St_FTk.v;
    ld_gnt    = 1'b0;
    st_gnt    = 1'b0;
`ifdef ROUND_ROBIN_ARB_EN
    st_last_d = st_last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (I_Boot) begin
          state_d  = S_PAD;
          cnt_d    = '0;
          tok_v_d  = 1'b1;
          tok_a_d  = 1'b1;
          d_hold_d = '0;
        end
      end
      S_PAD: begin
        if (!I_Ld_BTk.n) begin
          tok_a_d = 1'b0;
          if (cnt_q == PAD_LAST) begin
            // Fetch word 0 now so data follows the last pad with no bubble
            state_d  = S_DATA;
            cnt_d    = '0;
            mem_en   = 1'b1;
            mem_addr = boot_addr('0);
            fresh_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_DATA: begin
        if (!I_Ld_BTk.n) begin
          if (cnt_inc == LEN_END) begin
            state_d = S_RUN;
            cnt_d   = '0;
            tok_v_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d    = cnt_inc;
            mem_en   = 1'b1;
            mem_addr = boot_addr(cnt_inc);
            fresh_d  = 1'b1;
          end
        end else begin
          // Re-read the presented word so the memory keeps driving it
          mem_en   = 1'b1;
          mem_addr = boot_addr(cnt_q);
          fresh_d  = 1'b1;
        end
      end
      S_RUN: begin
`ifdef ROUND_ROBIN_ARB_EN
        st_gnt = st_req & ~(ld_req & st_last_q);
`else
        st_gnt = st_req;
`endif
        ld_gnt = ld_req & ~st_gnt;
        st_n   = st_req & ~st_gnt;
        if (st_gnt) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = I_St_Addr;
          mem_wdata = I_St_FTk.d;
        end
        if (ld_gnt) begin
          mem_en   = 1'b1;
          mem_addr = I_Ld_Addr;
          tok_v_d  = 1'b1;
          fresh_d  = 1'b1;
        end else begin
          tok_v_d = ld_stall;
        end
        tok_a_d = 1'b0;
`ifdef ROUND_ROBIN_ARB_EN
        if (st_gnt) st_last_d = 1'b1;
        else if (ld_gnt) st_last_d = 1'b0;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Token data comes straight from memory on the cycle after a read, else from the hold register
  always_comb begin
    ld_d = '0;
    if (tok_v_q && !reset) ld_d = fresh_q ? I_Mem_RData : d_hold_q;
  end

  assign O_Ld_FTk.v   = tok_v_q;
  assign O_Ld_FTk.a   = tok_a_q;
  assign O_Ld_FTk.r   = 1'b0;
  assign O_Ld_FTk.c   = 1'b0;
  assign O_Ld_FTk.d   = ld_d;
  assign O_St_BTk.n   = st_n & ~reset;
  assign O_Mem_En     = mem_en & ~reset;
  assign O_Mem_We     = mem_we & ~reset;
  assign O_Mem_Addr   = reset ? '0 : mem_addr;
  assign O_Mem_WData  = reset ? '0 : mem_wdata;
  assign O_Boot_Done  = done_q;

endmodule

// File: tb/tb_ext_mem_port_ctrl.sv
// Scoreboard bench for ext_mem_port_ctrl: boot stream, nack hold, RUN load/store arbitration, reset abort.
module tb_ext_mem_port_ctrl;
  import ext_mem_port_ctrl_pkg::*;

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    I_Boot, I_Ld_Req, I_St_Req;
  logic [WIDTH_EXADDR-1:0] I_Ld_Addr, I_St_Addr, O_Mem_Addr;
  FTk_t                    O_Ld_FTk, I_St_FTk;
  BTk_t                    I_Ld_BTk, O_St_BTk;
  logic                    O_Mem_En, O_Mem_We, O_Boot_Done;
  logic [WIDTH_DATA-1:0]   O_Mem_WData, I_Mem_RData;

  always #5 clock = ~clock;

  ext_mem_port_ctrl dut (
    .clock(clock), .reset(reset), .I_Boot(I_Boot),
    .I_Ld_Req(I_Ld_Req), .I_Ld_Addr(I_Ld_Addr), .O_Ld_FTk(O_Ld_FTk), .I_Ld_BTk(I_Ld_BTk),
    .I_St_Req(I_St_Req), .I_St_Addr(I_St_Addr), .I_St_FTk(I_St_FTk), .O_St_BTk(O_St_BTk),
    .O_Mem_En(O_Mem_En), .O_Mem_We(O_Mem_We), .O_Mem_Addr(O_Mem_Addr),
    .O_Mem_WData(O_Mem_WData), .I_Mem_RData(I_Mem_RData), .O_Boot_Done(O_Boot_Done)
  );

  // Single-port memory, 1-cycle read latency, with a preload port for the bench
  logic [31:0] mem [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  always @(posedge clock) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (O_Mem_En && O_Mem_We) mem[O_Mem_Addr[7:0]] <= O_Mem_WData;
    if (O_Mem_En && !O_Mem_We) I_Mem_RData <= mem[O_Mem_Addr[7:0]];
  end

  typedef struct packed { logic a; logic [31:0] d; } exp_t;
  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic a, input logic [31:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    q.push_back(e);
  endtask

  task automatic push_boot(input int n_words);
    logic [31:0] words [5];
    words = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    push(1'b1, 32'h0);
    push(1'b0, 32'h0);
    push(1'b0, 32'h0);
    for (int i = 0; i < n_words; i++) push(1'b0, words[i]);
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clock); #1;
    pre_we = 1'b0;
  endtask

  task automatic step;
    @(posedge clock); #1;
  endtask

  // Monitor: every accepted load token must match the head of the scoreboard
  always @(negedge clock) begin
    if (!reset && O_Ld_FTk.v && !I_Ld_BTk.n) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL ld_unexpected: got d=%h a=%b, nothing expected", O_Ld_FTk.d, O_Ld_FTk.a);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("ld_token", 64'({O_Ld_FTk.a, O_Ld_FTk.r, O_Ld_FTk.c, O_Ld_FTk.d}),
              64'({e.a, 2'b00, e.d}));
      end
    end
  end

  int  cnt33;
  bit  drained;

  initial begin
    reset = 1'b1; I_Boot = 0; I_Ld_Req = 0; I_St_Req = 0;
    I_Ld_Addr = '0; I_St_Addr = '0; I_St_FTk = '0; I_Ld_BTk = '0;
    repeat (2) step();
    preload(8'h00, 32'h11); preload(8'h01, 32'h22); preload(8'h02, 32'h33);
    preload(8'h03, 32'h44); preload(8'h04, 32'h55);
    preload(8'h10, 32'hDEAD); preload(8'h40, 32'hCAFE);
    @(negedge clock);
    check("reset_ld_tok", 64'(O_Ld_FTk), 64'h0);
    check("reset_misc", 64'({O_St_BTk, O_Mem_En, O_Mem_We, O_Mem_Addr, O_Mem_WData, O_Boot_Done}), 64'h0);
    step();
    reset = 1'b0;
    @(negedge clock);
    check("idle_outs", 64'({O_St_BTk.n, O_Mem_En, O_Ld_FTk.v}), 64'b100);
    step();

    // Boot with a 2-cycle nack while 0x33 is presented
    push_boot(5);
    I_Boot = 1'b1; step(); I_Boot = 1'b0;
    cnt33 = 0;
    for (int c = 1; c <= 12; c++) begin
      I_Ld_BTk.n = (c == 6 || c == 7);
      @(negedge clock);
      if (O_Ld_FTk.v && O_Ld_FTk.d == 32'h33) cnt33++;
      if (c == 6) check("nack_mem_reread", 64'({O_Mem_En, O_Mem_We, O_Mem_Addr}), 64'({2'b10, 16'h2}));
      if (c == 10) check("done_before_end", 64'(O_Boot_Done), 64'h0);
      if (c == 11) check("boot_end", 64'({O_Ld_FTk.v, O_Boot_Done}), 64'b01);
      step();
    end
    I_Ld_BTk.n = 1'b0;
    check("nack_hold_cycles", 64'(cnt33), 64'd3);

    // RUN load
    I_Ld_Req = 1; I_Ld_Addr = 16'h10; push(1'b0, 32'hDEAD);
    @(negedge clock);
    check("ld_grant", 64'({O_Mem_En, O_Mem_We, O_Mem_Addr}), 64'({2'b10, 16'h10}));
    step(); I_Ld_Req = 0;
    @(negedge clock); step();

    // Store then load of the same address
    I_St_Req = 1; I_St_Addr = 16'h20; I_St_FTk = '0; I_St_FTk.v = 1; I_St_FTk.d = 32'hBEEF;
    @(negedge clock);
    check("st_grant", 64'({O_Mem_En, O_Mem_We, O_Mem_Addr, O_Mem_WData}), 64'({2'b11, 16'h20, 32'hBEEF}));
    check("st_accept", 64'(O_St_BTk.n), 64'h0);
    step();
    I_St_Req = 0; I_St_FTk = '0; I_Ld_Req = 1; I_Ld_Addr = 16'h20; push(1'b0, 32'hBEEF);
    @(negedge clock);
    check("raw_ld_grant", 64'({O_Mem_En, O_Mem_We, O_Mem_Addr}), 64'({2'b10, 16'h20}));
    step(); I_Ld_Req = 0;
    @(negedge clock); step();

    // Simultaneous load and store requests for 4 cycles
    for (int i = 0; i < 4; i++) begin
      logic exp_st;
`ifdef ROUND_ROBIN_ARB_EN
      exp_st = (i % 2 == 1);
`else
      exp_st = 1'b1;
`endif
      I_Ld_Req = 1; I_Ld_Addr = 16'h10;
      I_St_Req = 1; I_St_Addr = 16'h30; I_St_FTk = '0; I_St_FTk.v = 1; I_St_FTk.d = 32'h100 + 32'(i);
      if (!exp_st) push(1'b0, 32'hDEAD);
      @(negedge clock);
      check("arb_grant", 64'({O_Mem_En, O_Mem_We}), 64'({1'b1, exp_st}));
      check("arb_st_btk", 64'(O_St_BTk.n), 64'(!exp_st));
      step();
    end
    I_St_Req = 0; I_St_FTk = '0;
    I_Ld_Addr = 16'h30; push(1'b0, 32'h103);
    @(negedge clock); step();
    I_Ld_Req = 0;
    @(negedge clock); step();

    // Load output stall: stores still proceed, no new loads until released
    I_Ld_Req = 1; I_Ld_Addr = 16'h10; push(1'b0, 32'hDEAD);
    step();
    I_Ld_BTk.n = 1; I_Ld_Addr = 16'h40;
    I_St_Req = 1; I_St_Addr = 16'h50; I_St_FTk = '0; I_St_FTk.v = 1; I_St_FTk.d = 32'h1234;
    @(negedge clock);
    check("stall_st_grant", 64'({O_Mem_En, O_Mem_We, O_Mem_Addr}), 64'({2'b11, 16'h50}));
    check("stall_tok1", 64'({O_Ld_FTk.v, O_Ld_FTk.d}), 64'({1'b1, 32'hDEAD}));
    step();
    I_St_Req = 0; I_St_FTk = '0;
    @(negedge clock);
    check("stall_no_ld", 64'(O_Mem_En), 64'h0);
    check("stall_tok2", 64'({O_Ld_FTk.v, O_Ld_FTk.d}), 64'({1'b1, 32'hDEAD}));
    step();
    I_Ld_BTk.n = 0; push(1'b0, 32'hCAFE);
    @(negedge clock);
    check("release_ld_grant", 64'({O_Mem_En, O_Mem_We, O_Mem_Addr}), 64'({2'b10, 16'h40}));
    step(); I_Ld_Req = 0;
    @(negedge clock); step();

    // I_Boot is ignored in RUN
    I_Boot = 1;
    @(negedge clock);
    check("run_boot_ignored", 64'({O_Mem_En, O_Ld_FTk.v, O_Boot_Done}), 64'b001);
    step(); I_Boot = 0;
    @(negedge clock);
    check("run_boot_ignored2", 64'({O_Mem_En, O_Ld_FTk.v}), 64'b00);
    step();

    // Return to IDLE, then abort a boot after two data words with reset
    reset = 1; step(); reset = 0; step();
    push_boot(2);
    I_Boot = 1; step(); I_Boot = 0;
    drained = 0;
    for (int c = 0; c < 20 && !drained; c++) begin
      @(negedge clock); #1;
      if (q.size() == 0) drained = 1;
    end
    check("abort_drain", 64'(drained), 64'h1);
    step();
    reset = 1;
    step();
    @(negedge clock);
    check("abort_ld_tok", 64'(O_Ld_FTk), 64'h0);
    check("abort_misc", 64'({O_St_BTk, O_Mem_En, O_Mem_We, O_Mem_Addr, O_Mem_WData, O_Boot_Done}), 64'h0);
    step();
    reset = 0;
    q.delete();
    step();

    // Full clean re-boot
    push_boot(5);
    I_Boot = 1; step(); I_Boot = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clock);
      if (c == 1) check("reboot_first_pad", 64'({O_Ld_FTk.v, O_Ld_FTk.a}), 64'b11);
      if (c == 8) check("reboot_done_low", 64'(O_Boot_Done), 64'h0);
      if (c == 9) check("reboot_end", 64'({O_Ld_FTk.v, O_Boot_Done}), 64'b01);
      step();
    end

    check("sb_drained", 64'(q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
